// File: rtl/operand_fetch.sv
// operand_fetch: register-bank operand fetch with a registered-ready output/skid buffer pair.
// Defining OPFETCH_BYPASS_EN forwards same-cycle bank writes (ALUBus) into captured and held operands.
module operand_fetch #(
  parameter int WIDTH   = 16,
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   r0,
  input  logic [WIDTH-1:0]   r1,
  input  logic [WIDTH-1:0]   r2,
  input  logic [WIDTH-1:0]   r3,
  input  logic [WIDTH-1:0]   r4,
  input  logic [WIDTH-1:0]   r5,
  input  logic [WIDTH-1:0]   r6,
  input  logic [WIDTH-1:0]   r7,
  input  logic [WIDTH-1:0]   r8,
  input  logic [WIDTH-1:0]   r9,
  input  logic [WIDTH-1:0]   r10,
  input  logic [WIDTH-1:0]   r11,
  input  logic [WIDTH-1:0]   r12,
  input  logic [WIDTH-1:0]   r13,
  input  logic [WIDTH-1:0]   r14,
  input  logic [WIDTH-1:0]   r15,
  input  logic [15:0]        regEnable,
  input  logic [WIDTH-1:0]   ALUBus,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         srcA_sel,
  input  logic [3:0]         srcB_sel,
  input  logic [WIDTH-1:0]   imm,
  input  logic               use_imm,
  input  logic [3:0]         dest_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [3:0]         dest_out,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               write_err
);
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
`ifdef OPFETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       d;
    logic [3:0]       sa;
    logic [3:0]       sb;
    logic             im;
  } entry_t;
  // Source indices travel with each entry so held operands can pick up later bank writes.
  function automatic entry_t upd(input entry_t e, input logic [15:0] h, input logic [WIDTH-1:0] bus);
    entry_t u;
    u = e;
    u.a = h[e.sa] ? bus : e.a;
    u.b = (h[e.sb] && !e.im) ? bus : e.b;
    return u;
  endfunction
  logic [15:0][WIDTH-1:0] rf;
  logic [15:0]            hit;
  logic [1:0]             state_q, state_d;
  logic                   in_ready_q, acc, err_q, err_d;
  logic [STALL_W-1:0]     stall_q, stall_d;
  entry_t                 out_q, out_d, sk_q, sk_d, out_h, sk_h, cap;
  assign rf  = {r15, r14, r13, r12, r11, r10, r9, r8, r7, r6, r5, r4, r3, r2, r1, r0};
  assign hit = BYP ? regEnable : 16'h0;
  assign acc = in_valid & in_ready_q;
  assign out_valid = state_q != EMPTY;
  assign in_ready  = in_ready_q;
  assign A         = out_q.a;
  assign B         = out_q.b;
  assign dest_out  = out_q.d;
  assign stall_cnt = stall_q;
  assign write_err = err_q;
  assign stall_d = (out_valid && !out_ready && !(&stall_q)) ? stall_q + STALL_W'(1) : stall_q;
  assign err_d   = err_q | (|(regEnable & (regEnable - 16'd1)));
  always_comb begin
    cap.a  = hit[srcA_sel] ? ALUBus : rf[srcA_sel];
    cap.b  = use_imm ? imm : hit[srcB_sel] ? ALUBus : rf[srcB_sel];
    cap.d  = dest_in;
    cap.sa = srcA_sel;
    cap.sb = srcB_sel;
    cap.im = use_imm;
    out_h  = upd(out_q, hit, ALUBus);
    sk_h   = upd(sk_q, hit, ALUBus);
    state_d = state_q;
    out_d   = out_h;
    sk_d    = sk_h;
    case (state_q)
      EMPTY: begin
        state_d = acc ? ONE : EMPTY;
        out_d   = acc ? cap : out_h;
      end
      ONE: begin
        state_d = (acc && !out_ready) ? FULL : (!acc && out_ready) ? EMPTY : ONE;
        out_d   = (acc && out_ready) ? cap : out_h;
        sk_d    = (acc && !out_ready) ? cap : sk_h;
      end
      FULL: begin
        state_d = out_ready ? ONE : FULL;
        out_d   = out_ready ? sk_h : out_h;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      sk_q       <= '0;
      stall_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= state_d != FULL;
      out_q      <= out_d;
      sk_q       <= sk_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width of the register bank and operands.
REQ-002 Parameter: STALL_W, default 8, width of the stall counter.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-005 r0..r15  input  WIDTH each  current register bank contents.
REQ-006 regEnable  input  16  one-hot bank write enables active this cycle.
REQ-007 ALUBus  input  WIDTH  bank write data this cycle.
REQ-008 in_valid  input  1  upstream request valid.
REQ-009 in_ready  output  1  request accepted this cycle when high with in_valid.
REQ-010 srcA_sel  input  4  register index for operand A.
REQ-011 srcB_sel  input  4  register index for operand B.
REQ-012 imm  input  WIDTH  immediate operand.
REQ-013 use_imm  input  1  B sources imm instead of register.
REQ-014 dest_in  input  4  destination index, passed through.
REQ-015 out_valid  output  1  A/B/dest_out valid to downstream.
REQ-016 out_ready  input  1  downstream takes the output when high with out_valid.
REQ-017 A, B  output  WIDTH each  fetched operands.
REQ-018 dest_out  output  4  destination index of the presented entry.
REQ-019 stall_cnt  output  STALL_W  cycles spent with out_valid=1 and out_ready=0.
REQ-020 write_err  output  1  sticky flag: regEnable seen non-one-hot.

Function
REQ-021 Accept = in_valid & in_ready; capture A=r[srcA_sel], B=use_imm?imm:r[srcB_sel], dest_in, on the accepting edge.
REQ-022 Storage: output entry plus one skid entry; in_ready SHALL be a registered signal equal to "skid empty".
REQ-023 States: EMPTY (out_valid=0), ONE (output held, skid empty), FULL (both held, in_ready=0).
REQ-024 EMPTY+accept -> ONE; out_valid rises one cycle after the accepting edge (latency 1).
REQ-025 ONE+accept+out_ready -> ONE, output replaced by new entry; ONE+accept+!out_ready -> FULL, new entry into skid.
REQ-026 ONE+!accept+out_ready -> EMPTY; ONE with neither -> ONE, outputs stable.
REQ-027 FULL+out_ready -> ONE, skid entry moves to output next edge; FULL+!out_ready -> FULL.
REQ-028 Order SHALL be preserved; no entry dropped or duplicated; A/B/dest_out SHALL NOT change while out_valid=1 and out_ready=0, except per REQ-036.
REQ-029 stall_cnt increments each cycle out_valid & !out_ready; saturates at all-ones; never wraps.
REQ-030 write_err sets when more than one regEnable bit is high in a cycle; clears only by reset.
REQ-031 regEnable all-zero is legal (no write).

Reset
REQ-032 While reset=0: out_valid=0, skid empty, in_ready=1, A=B=0, dest_out=0, stall_cnt=0, write_err=0.
REQ-033 Reset assertion mid-operation SHALL discard all held entries immediately, without waiting for clk.
REQ-034 First accept possible on the first rising edge after reset deasserts.

Configuration
REQ-035 Macro OPFETCH_BYPASS_EN: when defined, a capture whose source index has regEnable bit set that cycle takes ALUBus instead of r[sel] (B only if use_imm=0).
REQ-036 With OPFETCH_BYPASS_EN, held output and skid operands whose source index is written take ALUBus at that edge; without it, operands are frozen at capture and the bank write is not observed.

Verification
REQ-037 Reset, in_valid=1 srcA=3 srcB=5 use_imm=0 with r3=0x1111 r5=0x2222, out_ready=1 -> next cycle out_valid=1 A=0x1111 B=0x2222.
REQ-038 out_ready=0, three back-to-back requests -> first two accepted, in_ready=0 after second, stall_cnt counts; out_ready=1 -> entries emerge in order, in_ready returns 1.
REQ-039 Bypass build: accept srcA=7 while regEnable=0x0080 ALUBus=0xBEEF, r7=0x0000 -> A=0xBEEF; non-bypass build -> A=0x0000.
REQ-040 Bypass build: entry held stalled with srcB=2, write regEnable=0x0004 ALUBus=0x00AA -> B becomes 0x00AA; use_imm=1 entry unchanged.
REQ-041 regEnable=0x0003 one cycle -> write_err=1 and stays 1 until reset.
REQ-042 FULL state, assert reset asynchronously mid-cycle -> out_valid=0, in_ready=1, stall_cnt=0 before next edge.
